maint_req_arbiter: RTL and testbench

MAINT_REQ_ARBITER -- requirements
Module: maint_req_arbiter

---
 rtl/maint_req_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_maint_req_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maint_req_arbiter.sv
// maint_req_arbiter
//   Arbitrates three maintenance requesters (auto-refresh, ZQ calibration,
//   periodic read) onto a single maintenance handler. Fixed priority
//   aref > zq > prrd, with per-requester age counters: a request that has
//   waited AGE_LIMIT cycles becomes urgent, wins over non-urgent requests
//   and overrides app_busy_i.
//
//   Optional feature: define MAINT_ARB_STATS_EN to build 16-bit per-requester
//   grant counters. Without it the stat_*_o outputs are tied to zero.
//
// Ports
//   clk            clock, rising edge
//   rst            synchronous active-high reset
//   aref_req_i     auto-refresh request (level, held until aref_ack_o)
//   zq_req_i       ZQ calibration request (level, held until zq_ack_o)
//   prrd_req_i     periodic-read request (level, held until prrd_ack_o)
//   app_busy_i     dispatcher busy with app sequence; defers non-urgent grants
//   grant_valid_o  grant offered to the maintenance handler
//   grant_id_o     granted requester: 0=aref 1=zq 2=prrd (0 when not valid)
//   grant_ack_i    handler accepted the grant (one-cycle pulse)
//   aref_ack_o     one-cycle completion pulse to aref requester
//   zq_ack_o       one-cycle completion pulse to zq requester
//   prrd_ack_o     one-cycle completion pulse to prrd requester
//   urgent_o       some pending request has reached AGE_LIMIT
//   stat_aref_o    aref grant counter
//   stat_zq_o      zq grant counter
//   stat_prrd_o    prrd grant counter
module maint_req_arbiter #(
  parameter int unsigned AGE_WIDTH = 8,
  parameter int unsigned AGE_LIMIT = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        aref_req_i,
  input  logic        zq_req_i,
  input  logic        prrd_req_i,
  input  logic        app_busy_i,
  output logic        grant_valid_o,
  output logic [1:0]  grant_id_o,
  input  logic        grant_ack_i,
  output logic        aref_ack_o,
  output logic        zq_ack_o,
  output logic        prrd_ack_o,
  output logic        urgent_o,
  output logic [15:0] stat_aref_o,
  output logic [15:0] stat_zq_o,
  output logic [15:0] stat_prrd_o
);

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StAck
  } state_e;

  localparam logic [AGE_WIDTH-1:0] AgeLimit = AGE_WIDTH'(AGE_LIMIT);

  state_e         state_q, state_d;
  // Requester id held through GRANT and ACK; grant_id_o itself drops to 0 in ACK.
  logic [1:0]     sel_q, sel_d;
  logic           grant_valid_q, grant_valid_d;
  logic [1:0]     grant_id_q, grant_id_d;
  logic [2:0]     ack_q, ack_d;
  logic           urgent_q, urgent_d;
  logic [AGE_WIDTH-1:0] age_q [3];
  logic [AGE_WIDTH-1:0] age_d [3];

  logic [2:0] req;
  logic [2:0] sel_onehot;
  logic [2:0] in_ack;
  logic [2:0] owned;
  logic [2:0] pending;
  logic [2:0] urgent_vec;
  logic [2:0] cand;
  logic [1:0] pick;

  assign req        = {prrd_req_i, zq_req_i, aref_req_i};
  assign sel_onehot = 3'b001 << sel_q;
  assign in_ack     = (state_q == StAck) ? sel_onehot : 3'b000;
  // A requester owns the arbiter from the cycle its grant is offered until its ack.
  assign owned      = (state_q != StIdle) ? sel_onehot : 3'b000;
  assign pending    = req & ~in_ack;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      urgent_vec[i] = pending[i] && (age_q[i] == AgeLimit);
    end
  end

  // Urgent requesters are arbitrated first; otherwise all pending ones.
  assign cand = (|urgent_vec) ? urgent_vec : pending;

  always_comb begin
    pick = 2'd0;
    if (cand[0]) begin
      pick = 2'd0;
    end else if (cand[1]) begin
      pick = 2'd1;
    end else if (cand[2]) begin
      pick = 2'd2;
    end
  end

  // Age counters: clear when idle-requested or owned, otherwise saturate at the limit.
  always_comb begin
    urgent_d = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (!req[i] || owned[i]) begin
        age_d[i] = '0;
      end else if (age_q[i] == AgeLimit) begin
        age_d[i] = age_q[i];
      end else begin
        age_d[i] = age_q[i] + 1'b1;
      end
      if (age_d[i] == AgeLimit) begin
        urgent_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    ack_d         = 3'b000;
    unique case (state_q)
      StIdle: begin
        if ((|pending) && (!app_busy_i || urgent_q)) begin
          state_d       = StGrant;
          sel_d         = pick;
          grant_valid_d = 1'b1;
          grant_id_d    = pick;
        end
      end
      StGrant: begin
        if (grant_ack_i) begin
          state_d       = StAck;
          grant_valid_d = 1'b0;
          grant_id_d    = 2'd0;
          ack_d         = sel_onehot;
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d       = StIdle;
        grant_valid_d = 1'b0;
        grant_id_d    = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      sel_q         <= 2'd0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= 2'd0;
      ack_q         <= 3'b000;
      urgent_q      <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      ack_q         <= ack_d;
      urgent_q      <= urgent_d;
      for (int i = 0; i < 3; i++) begin
        age_q[i] <= age_d[i];
      end
    end
  end

  assign grant_valid_o = grant_valid_q;
  assign grant_id_o    = grant_id_q;
  assign aref_ack_o    = ack_q[0];
  assign zq_ack_o      = ack_q[1];
  assign prrd_ack_o    = ack_q[2];
  assign urgent_o      = urgent_q;

`ifdef MAINT_ARB_STATS_EN
  logic [15:0] stat_q [3];

  // Counts land in the same cycle the ack pulse is visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        stat_q[i] <= 16'd0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (ack_d[i]) begin
          stat_q[i] <= stat_q[i] + 16'd1;
        end
      end
    end
  end

  assign stat_aref_o = stat_q[0];
  assign stat_zq_o   = stat_q[1];
  assign stat_prrd_o = stat_q[2];
`else
  assign stat_aref_o = 16'd0;
  assign stat_zq_o   = 16'd0;
  assign stat_prrd_o = 16'd0;
`endif

endmodule

// File: tb/tb_maint_req_arbiter.sv
// Self-checking bench for maint_req_arbiter: directed scenarios with literal
// expectations plus randomized traffic, all checked every cycle against a
// transaction-level model (who holds the grant, who is being acked, ages).
module tb_maint_req_arbiter;

  localparam int Limit = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic        app_busy;
  logic        grant_ack;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic        aref_ack, zq_ack, prrd_ack;
  logic        urgent;
  logic [15:0] stat_aref, stat_zq, stat_prrd;
  logic [2:0]  acks;

  int errors = 0;
  int checks = 0;

  // Model state: holder of the offered grant (-1 none), requester being acked (-1 none).
  int m_gnt;
  int m_ack;
  int m_age [3];
  bit m_urg;
  int m_stat [3];

  always #5 clk = ~clk;

  assign acks = {prrd_ack, zq_ack, aref_ack};

  maint_req_arbiter #(
    .AGE_WIDTH(8),
    .AGE_LIMIT(Limit)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .aref_req_i   (req[0]),
    .zq_req_i     (req[1]),
    .prrd_req_i   (req[2]),
    .app_busy_i   (app_busy),
    .grant_valid_o(grant_valid),
    .grant_id_o   (grant_id),
    .grant_ack_i  (grant_ack),
    .aref_ack_o   (aref_ack),
    .zq_ack_o     (zq_ack),
    .prrd_ack_o   (prrd_ack),
    .urgent_o     (urgent),
    .stat_aref_o  (stat_aref),
    .stat_zq_o    (stat_zq),
    .stat_prrd_o  (stat_prrd)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int old_age [3];
    int pick;
    old_age = m_age;
    if (rst) begin
      m_gnt  = -1;
      m_ack  = -1;
      m_age  = '{0, 0, 0};
      m_urg  = 1'b0;
      m_stat = '{0, 0, 0};
      return;
    end
    for (int r = 0; r < 3; r++) begin
      if (!req[r] || m_gnt == r || m_ack == r) m_age[r] = 0;
      else m_age[r] = (old_age[r] + 1 > Limit) ? Limit : old_age[r] + 1;
    end
    if (m_ack >= 0) begin
      m_ack = -1;
    end else if (m_gnt >= 0) begin
      if (grant_ack) begin
        m_ack = m_gnt;
`ifdef MAINT_ARB_STATS_EN
        m_stat[m_ack] = (m_stat[m_ack] + 1) % 65536;
`endif
        m_gnt = -1;
      end
    end else if (req != 3'b000 && (!app_busy || m_urg)) begin
      pick = -1;
      for (int r = 0; r < 3; r++) if (pick < 0 && req[r] && old_age[r] == Limit) pick = r;
      for (int r = 0; r < 3; r++) if (pick < 0 && req[r]) pick = r;
      m_gnt = pick;
    end
    m_urg = 1'b0;
    for (int r = 0; r < 3; r++) if (m_age[r] == Limit) m_urg = 1'b1;
  endtask

  task automatic check_all();
    chk("grant_valid", int'(grant_valid), (m_gnt >= 0) ? 1 : 0);
    chk("grant_id", int'(grant_id), (m_gnt >= 0) ? m_gnt : 0);
    chk("aref_ack", int'(aref_ack), (m_ack == 0) ? 1 : 0);
    chk("zq_ack", int'(zq_ack), (m_ack == 1) ? 1 : 0);
    chk("prrd_ack", int'(prrd_ack), (m_ack == 2) ? 1 : 0);
    chk("urgent", int'(urgent), int'(m_urg));
    chk("stat_aref", int'(stat_aref), m_stat[0]);
    chk("stat_zq", int'(stat_zq), m_stat[1]);
    chk("stat_prrd", int'(stat_prrd), m_stat[2]);
    chk("ack_onehot", ($countones(acks) <= 1) ? 1 : 0, 1);
  endtask

  // Inputs are only changed at the negedge, so the model sees what the DUT sampled.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  // Wait (bounded) for a grant, accept it, and let the requester drop on its ack.
  task automatic serve(output int id);
    int n = 0;
    while (!grant_valid && n < 50) begin
      cycle();
      n++;
    end
    if (!grant_valid) begin
      chk("grant_timeout", 0, 1);
      id = -1;
      return;
    end
    id = int'(grant_id);
    grant_ack = 1'b1;
    cycle();
    grant_ack = 1'b0;
    for (int r = 0; r < 3; r++) if (acks[r]) req[r] = 1'b0;
    cycle();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int id;
    int n;
    bit busy_hold;
    rst       = 1'b1;
    req       = 3'b000;
    app_busy  = 1'b0;
    grant_ack = 1'b0;
    m_gnt     = -1;
    m_ack     = -1;
    m_age     = '{0, 0, 0};
    m_urg     = 1'b0;
    m_stat    = '{0, 0, 0};
    cycle();
    cycle();
    chk("rst_grant_valid", int'(grant_valid), 0);
    chk("rst_grant_id", int'(grant_id), 0);
    chk("rst_acks", int'(acks), 0);
    chk("rst_urgent", int'(urgent), 0);
    chk("rst_stat_aref", int'(stat_aref), 0);
    rst = 1'b0;
    cycle();

    // Single aref request, accepted three cycles after the grant appears.
    req[0] = 1'b1;
    cycle();
    chk("aref_grant_valid", int'(grant_valid), 1);
    chk("aref_grant_id", int'(grant_id), 0);
    cycle();
    cycle();
    grant_ack = 1'b1;
    cycle();
    grant_ack = 1'b0;
    chk("aref_ack_pulse", int'(aref_ack), 1);
    chk("aref_valid_in_ack", int'(grant_valid), 0);
    req[0] = 1'b0;
    cycle();
    chk("aref_ack_single", int'(aref_ack), 0);
    chk("aref_idle_valid", int'(grant_valid), 0);
    cycle();

    // All three together: priority order 0,1,2.
    req = 3'b111;
    for (int k = 0; k < 3; k++) begin
      serve(id);
      chk("prio_order", id, k);
    end
    cycle();

    // prrd held under app_busy waits for urgency, then wins despite busy.
    app_busy = 1'b1;
    req      = 3'b100;
    n        = 0;
    while (!urgent && n < 300) begin
      cycle();
      n++;
    end
    chk("urgent_latency", n, Limit);
    chk("urgent_no_grant_yet", int'(grant_valid), 0);
    cycle();
    chk("urgent_grant_valid", int'(grant_valid), 1);
    chk("urgent_grant_id", int'(grant_id), 2);
    serve(id);
    app_busy = 1'b0;
    cycle();

    // zq drops its request mid-grant: ack still pulses once.
    req = 3'b010;
    cycle();
    chk("zq_grant_id", int'(grant_id), 1);
    req[1] = 1'b0;
    cycle();
    cycle();
    chk("zq_grant_held", int'(grant_valid), 1);
    grant_ack = 1'b1;
    cycle();
    grant_ack = 1'b0;
    chk("zq_ack_pulse", int'(zq_ack), 1);
    cycle();
    chk("zq_ack_single", int'(zq_ack), 0);
    // Stray grant_ack in IDLE.
    grant_ack = 1'b1;
    cycle();
    grant_ack = 1'b0;
    chk("stray_ack_none", int'(acks), 0);
    cycle();
    chk("stray_ack_none2", int'(acks), 0);

    // Reset during GRANT abandons the grant.
    app_busy = 1'b1;
    req      = 3'b001;
    repeat (5) cycle();
    app_busy = 1'b0;
    cycle();
    chk("pre_rst_grant", int'(grant_valid), 1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    req = 3'b000;
    chk("rst_in_grant_valid", int'(grant_valid), 0);
    chk("rst_in_grant_acks", int'(acks), 0);
    chk("rst_in_grant_stat", int'(stat_aref), 0);
    cycle();
    chk("rst_in_grant_noack", int'(acks), 0);

    // Five aref grants feed the statistics counter.
    for (int k = 0; k < 5; k++) begin
      req[0] = 1'b1;
      serve(id);
    end
`ifdef MAINT_ARB_STATS_EN
    chk("stat_aref_5", int'(stat_aref), 5);
`else
    chk("stat_aref_5", int'(stat_aref), 0);
`endif

    // Randomized traffic.
    busy_hold = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      for (int r = 0; r < 3; r++) begin
        if (!req[r] && $urandom_range(0, 7) == 0) req[r] = 1'b1;
        else if (req[r] && $urandom_range(0, 149) == 0) req[r] = 1'b0;
      end
      if ($urandom_range(0, 299) == 0) busy_hold = ~busy_hold;
      app_busy  = busy_hold ? 1'b1 : ($urandom_range(0, 2) == 0);
      grant_ack = ($urandom_range(0, 3) == 0);
      cycle();
      for (int r = 0; r < 3; r++) if (acks[r]) req[r] = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
